// File: rtl/baseball_play_in.sv
// Scoreboard input engine: synchronizes and debounces five buttons, then applies
// hits and outs to produce batting team, base occupancy, outs and a run pulse.
module baseball_play_in #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int INNINGS         = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_single_n,
  input  logic       btn_double_n,
  input  logic       btn_triple_n,
  input  logic       btn_homer_n,
  input  logic       btn_out_n,
  output logic       team,
  output logic [2:0] base,
  output logic [3:0] add_to_score,
  output logic [1:0] outs,
  output logic       game_over
);

  localparam int NB     = 5;
  localparam int CNT_W  = 20;
  localparam int HALF_W = $clog2(2 * INNINGS + 1);

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_END = HALF_W'(2 * INNINGS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [3:0] runs_onehot(input logic [2:0] n);
    case (n)
      3'd1:    runs_onehot = 4'b0001;
      3'd2:    runs_onehot = 4'b0010;
      3'd3:    runs_onehot = 4'b0100;
      3'd4:    runs_onehot = 4'b1000;
      default: runs_onehot = 4'b0000;
    endcase
  endfunction

  // Bit order: 0 single, 1 double, 2 triple, 3 homer, 4 out.
  logic [NB-1:0]    btn_raw_n_s;
  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic             press_s;

  assign btn_raw_n_s = {btn_out_n, btn_homer_n, btn_triple_n, btn_double_n, btn_single_n};

  // Two-flop synchronizer on the raw active-low buttons.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {NB{1'b1}};
      sync2_q <= {NB{1'b1}};
    end else begin
      sync1_q <= btn_raw_n_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip the pressed level once the synchronized level disagrees for DEBOUNCE_CYCLES samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 0; i < NB; i++) begin
      if ((~sync2_q[i]) == deb_q[i]) begin
        cnt_d[i] = CNT_W'(0);
      end else if (cnt_q[i] == DB_LAST) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = CNT_W'(0);
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce level and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= CNT_W'(0);
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Acting on the edge the debounced level rises keeps the apply update at DEBOUNCE_CYCLES+3.
  assign press_s = |(deb_d & ~deb_q);

  state_t            state_q, state_d;
  logic [NB-1:0]     latch_q, latch_d;
  logic              team_q, team_d;
  logic [2:0]        base_q, base_d;
  logic [3:0]        add_q, add_d;
  logic [1:0]        outs_q, outs_d;
  logic              over_q, over_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] half_inc_s;
  logic [2:0]        hit_n_s;
  logic [3:0]        occ_s;
  logic [7:0]        shifted_s;

  // Number of bases for the latched button; zero when it is not a single hit button.
  always_comb begin
    case (latch_q)
      5'b00001: hit_n_s = 3'd1;
      5'b00010: hit_n_s = 3'd2;
      5'b00100: hit_n_s = 3'd3;
      5'b01000: hit_n_s = 3'd4;
      default:  hit_n_s = 3'd0;
    endcase
  end

  assign occ_s      = {base_q[0], base_q[1], base_q[2], 1'b1};
  assign shifted_s  = {4'b0000, occ_s} << hit_n_s;
  assign half_inc_s = half_q + HALF_W'(1);

  // Game FSM next-state and output computation.
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    team_d  = team_q;
    base_d  = base_q;
    add_d   = 4'b0000;
    outs_d  = outs_q;
    over_d  = over_q;
    half_d  = half_q;
    case (state_q)
      S_IDLE: begin
        if (press_s) begin
          state_d = S_APPLY;
          latch_d = deb_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        state_d = S_WAIT;
        case (latch_q)
          5'b00001, 5'b00010, 5'b00100, 5'b01000: begin
            base_d = {shifted_s[1], shifted_s[2], shifted_s[3]};
            add_d  = runs_onehot(popcount4(shifted_s[7:4]));
          end
          5'b10000: begin
            if (outs_q < 2'd2) begin
              outs_d = outs_q + 2'd1;
            end else begin
              outs_d = 2'd0;
              base_d = 3'b000;
              half_d = half_inc_s;
              if (half_inc_s == HALF_END) begin
                over_d  = 1'b1;
                state_d = S_OVER;
              end else begin
                team_d = ~team_q;
              end
            end
          end
          default: begin
            state_d = S_WAIT;
          end
        endcase
      end
      S_WAIT: begin
        // A press landing on the very edge everything reads released is still taken.
        if (deb_q == {NB{1'b0}}) begin
          if (press_s) begin
            state_d = S_APPLY;
            latch_d = deb_d;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered game outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      latch_q <= {NB{1'b0}};
      team_q  <= 1'b0;
      base_q  <= 3'b000;
      add_q   <= 4'b0000;
      outs_q  <= 2'd0;
      over_q  <= 1'b0;
      half_q  <= HALF_W'(0);
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      team_q  <= team_d;
      base_q  <= base_d;
      add_q   <= add_d;
      outs_q  <= outs_d;
      over_q  <= over_d;
      half_q  <= half_d;
    end
  end

  assign team         = team_q;
  assign base         = base_q;
  assign add_to_score = add_q;
  assign outs         = outs_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_baseball_play_in.sv
// Directed bench for baseball_play_in with DEBOUNCE_CYCLES=4 and INNINGS=1.
module tb_baseball_play_in;

  logic       clk;
  logic       reset_n;
  logic [4:0] btn_n;
  logic       team;
  logic [2:0] base;
  logic [3:0] add_to_score;
  logic [1:0] outs;
  logic       game_over;

  int n_checks;
  int n_err;
  int pulse_cnt;
  int p0;

  baseball_play_in #(.DEBOUNCE_CYCLES(4), .INNINGS(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_single_n (btn_n[0]),
    .btn_double_n (btn_n[1]),
    .btn_triple_n (btn_n[2]),
    .btn_homer_n  (btn_n[3]),
    .btn_out_n    (btn_n[4]),
    .team         (team),
    .base         (base),
    .add_to_score (add_to_score),
    .outs         (outs),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (add_to_score !== 4'b0000) pulse_cnt = pulse_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " team"}, {31'd0, team}, 32'd0);
    check({tag, " base"}, {29'd0, base}, 32'd0);
    check({tag, " add"}, {28'd0, add_to_score}, 32'd0);
    check({tag, " outs"}, {30'd0, outs}, 32'd0);
    check({tag, " over"}, {31'd0, game_over}, 32'd0);
  endtask

  // Press one button, verify no early update, the update on edge 7, the pulse width, then release.
  task automatic press(input int idx, input logic [2:0] e_base, input logic [3:0] e_add,
                       input logic [1:0] e_outs, input logic e_team, input logic e_over,
                       input int hold, input string tag);
    logic [2:0] b0;
    b0 = base;
    @(posedge clk); #1;
    btn_n[idx] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check({tag, " early base"}, {29'd0, base}, {29'd0, b0});
    check({tag, " early add"}, {28'd0, add_to_score}, 32'd0);
    @(posedge clk); #1;
    check({tag, " base"}, {29'd0, base}, {29'd0, e_base});
    check({tag, " add"}, {28'd0, add_to_score}, {28'd0, e_add});
    check({tag, " outs"}, {30'd0, outs}, {30'd0, e_outs});
    check({tag, " team"}, {31'd0, team}, {31'd0, e_team});
    check({tag, " over"}, {31'd0, game_over}, {31'd0, e_over});
    @(posedge clk); #1;
    check({tag, " add clear"}, {28'd0, add_to_score}, 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    btn_n[idx] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    pulse_cnt = 0;
    reset_n   = 1'b0;
    btn_n     = 5'b11111;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic single with a long hold.
    p0 = pulse_cnt;
    press(0, 3'b100, 4'b0000, 2'd0, 1'b0, 1'b0, 100, "single_hold");
    check("hold base", {29'd0, base}, {29'd0, 3'b100});
    check("hold pulses", pulse_cnt - p0, 32'd0);

    // Load the bases, then a grand slam.
    press(0, 3'b110, 4'b0000, 2'd0, 1'b0, 1'b0, 2, "single2");
    press(0, 3'b111, 4'b0000, 2'd0, 1'b0, 1'b0, 2, "single3");
    p0 = pulse_cnt;
    press(3, 3'b000, 4'b1000, 2'd0, 1'b0, 1'b0, 2, "grand_slam");
    check("slam pulses", pulse_cnt - p0, 32'd1);

    // Mixed advance.
    press(1, 3'b010, 4'b0000, 2'd0, 1'b0, 1'b0, 2, "double");
    press(0, 3'b101, 4'b0000, 2'd0, 1'b0, 1'b0, 2, "single_adv");
    press(2, 3'b001, 4'b0010, 2'd0, 1'b0, 1'b0, 2, "triple");

    // Runner on third scores on a single, then reload.
    press(0, 3'b100, 4'b0001, 2'd0, 1'b0, 1'b0, 2, "single_score");
    press(0, 3'b110, 4'b0000, 2'd0, 1'b0, 1'b0, 2, "reload2");
    press(0, 3'b111, 4'b0000, 2'd0, 1'b0, 1'b0, 2, "reload3");

    // Side retired with the bases loaded.
    p0 = pulse_cnt;
    press(4, 3'b111, 4'b0000, 2'd1, 1'b0, 1'b0, 2, "out1");
    press(4, 3'b111, 4'b0000, 2'd2, 1'b0, 1'b0, 2, "out2");
    press(4, 3'b000, 4'b0000, 2'd0, 1'b1, 1'b0, 2, "out3");
    check("outs pulses", pulse_cnt - p0, 32'd0);

    // Three-cycle glitch on double.
    p0 = pulse_cnt;
    @(posedge clk); #1;
    btn_n[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    btn_n[1] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("glitch base", {29'd0, base}, 32'd0);
    check("glitch pulses", pulse_cnt - p0, 32'd0);

    // Single and out together form an ignored set.
    btn_n[0] = 1'b0;
    btn_n[4] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("conflict base", {29'd0, base}, 32'd0);
    check("conflict outs", {30'd0, outs}, 32'd0);
    check("conflict team", {31'd0, team}, 32'd1);
    btn_n[0] = 1'b1;
    btn_n[4] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    press(0, 3'b100, 4'b0000, 2'd0, 1'b1, 1'b0, 2, "after_conflict");

    // Fresh game: six outs end it.
    reset_n = 1'b0;
    #1;
    check_reset("reset2");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    press(4, 3'b000, 4'b0000, 2'd1, 1'b0, 1'b0, 2, "g_out1");
    press(4, 3'b000, 4'b0000, 2'd2, 1'b0, 1'b0, 2, "g_out2");
    press(4, 3'b000, 4'b0000, 2'd0, 1'b1, 1'b0, 2, "g_out3");
    press(4, 3'b000, 4'b0000, 2'd1, 1'b1, 1'b0, 2, "g_out4");
    press(4, 3'b000, 4'b0000, 2'd2, 1'b1, 1'b0, 2, "g_out5");
    press(4, 3'b000, 4'b0000, 2'd0, 1'b1, 1'b1, 2, "g_out6");
    press(3, 3'b000, 4'b0000, 2'd0, 1'b1, 1'b1, 2, "over_homer");

    // Reset mid-debounce after game over.
    p0 = pulse_cnt;
    @(posedge clk); #1;
    btn_n[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset("mid_reset");
    btn_n[0] = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_reset("post_reset");
    check("post_reset pulses", pulse_cnt - p0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
